ddcb_delay_calib_ctrl: RTL and testbench



---
 rtl/ddcb_delay_calib_ctrl.sv | 126 ++++++++++++
 tb/tb_ddcb_delay_calib_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ddcb_delay_calib_ctrl.sv
// ddcb_delay_calib_ctrl: closed-loop delay-line calibration (acquire by sweep, then track) driving the stage bypass bus
// ports: clk, rst_n (sync, active-low) | start, stop pulses | pd_valid, pd_late phase-detector samples
//        select (1 = stage bypassed), code (inserted stages), busy, locked, err
module ddcb_delay_calib_ctrl #(
  parameter int NMBR_CASCADES = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_WIN = 8,
  parameter int CW = $clog2(NMBR_CASCADES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pd_valid,
  input  logic                     pd_late,
  output logic [NMBR_CASCADES-1:0] select,
  output logic [CW-1:0]            code,
  output logic                     busy,
  output logic                     locked,
  output logic                     err
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_ERROR} state_t;
  typedef enum logic [1:0] {D_NONE, D_UP, D_DN, D_HOLD} dir_t;
  localparam logic [7:0] HALF = 8'(AVG_WIN / 2);
  localparam logic [CW-1:0] CMAX = CW'(NMBR_CASCADES);
  state_t state_q, state_d;
  dir_t last_q, last_d, dir;
  logic [CW-1:0] code_q, code_d, step;
  logic [NMBR_CASCADES-1:0] sel_q, sel_d;
  logic acq_q, acq_d, lock_q, lock_d, sat, rev;
  logic [7:0] set_q, set_d, smp_q, smp_d, vot_q, vot_d;
  assign dir  = vot_q > HALF ? D_DN : vot_q < HALF ? D_UP : D_HOLD;
  assign sat  = (dir == D_DN && code_q == '0) || (dir == D_UP && code_q == CMAX);
  assign step = dir == D_UP ? code_q + CW'(1) : dir == D_DN ? code_q - CW'(1) : code_q;
  // a decision against the previous step direction means the edge was straddled
  assign rev  = last_q != D_NONE && dir != D_HOLD && dir != last_q;
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    acq_d   = acq_q;
    lock_d  = lock_q;
    last_d  = last_q;
    set_d   = set_q;
    smp_d   = smp_q;
    vot_d   = vot_q;
    if (stop) begin
      state_d = S_IDLE;
      acq_d   = 1'b0;
      lock_d  = 1'b0;
      set_d   = '0;
      smp_d   = '0;
      vot_d   = '0;
    end else if (start && !acq_q) begin
      state_d = S_SETTLE;
      code_d  = '0;
      acq_d   = 1'b1;
      lock_d  = 1'b0;
      last_d  = D_NONE;
      set_d   = '0;
      smp_d   = '0;
      vot_d   = '0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          set_d   = set_q == 8'(SETTLE_CYCLES - 1) ? '0 : set_q + 8'd1;
          state_d = set_q == 8'(SETTLE_CYCLES - 1) ? S_MEASURE : S_SETTLE;
        end
        S_MEASURE: if (pd_valid) begin
          smp_d   = smp_q + 8'd1;
          vot_d   = vot_q + 8'(pd_late);
          state_d = smp_q == 8'(AVG_WIN - 1) ? S_DECIDE : S_MEASURE;
        end
        S_DECIDE: begin
          smp_d   = '0;
          vot_d   = '0;
          state_d = S_SETTLE;
          if (sat) begin
            if (acq_q) begin
              state_d = S_ERROR;
              acq_d   = 1'b0;
            end
          end else begin
            code_d = step;
            if (acq_q && (dir == D_HOLD || rev)) begin
              acq_d  = 1'b0;
              lock_d = 1'b1;
            end else if (acq_q) begin
              last_d = dir;
            end
          end
        end
        default: ;
      endcase
    end
    sel_d = '1;
    for (int i = 0; i < NMBR_CASCADES; i++) sel_d[i] = i >= int'(code_d);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      sel_q   <= '1;
      acq_q   <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= D_NONE;
      set_q   <= '0;
      smp_q   <= '0;
      vot_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
      acq_q   <= acq_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      set_q   <= set_d;
      smp_q   <= smp_d;
      vot_q   <= vot_d;
    end
  end
  assign select = sel_q;
  assign code   = code_q;
  assign busy   = acq_q && (state_q == S_SETTLE || state_q == S_MEASURE || state_q == S_DECIDE);
  assign locked = lock_q;
  assign err    = state_q == S_ERROR;
endmodule

// File: tb/tb_ddcb_delay_calib_ctrl.sv
// tb_ddcb_delay_calib_ctrl: directed checks plus a window-level behavioural model compared every cycle
module tb_ddcb_delay_calib_ctrl;
  localparam int N = 4, ST = 4, AW = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, pd_valid = 1'b0, pd_late = 1'b0;
  logic [N-1:0] select;
  logic [2:0] code;
  logic busy, locked, err;
  int n_cmp = 0, n_fail = 0;
  int m_code = 0, m_last = 0, m_wait = 0;
  bit m_run = 0, m_acq = 0, m_lock = 0, m_err = 0, m_dec = 0, chk_en = 0;
  bit q[$];
  int pd_mode = 1, tgt = 2, alt = 0;
  bit pd_fix = 0;
  always #5 clk = ~clk;
  ddcb_delay_calib_ctrl #(.NMBR_CASCADES(N), .SETTLE_CYCLES(ST), .AVG_WIN(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pd_valid(pd_valid), .pd_late(pd_late),
    .select(select), .code(code), .busy(busy), .locked(locked), .err(err)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int thermo(input int c);
    int s = 0;
    for (int i = 0; i < N; i++) if (i >= c) s |= 1 << i;
    return s;
  endfunction
  task automatic decide();
    int v = 0, d, nc;
    foreach (q[i]) v += int'(q[i]);
    d = 2 * v > AW ? -1 : 2 * v < AW ? 1 : 0;
    nc = m_code + d;
    if (nc < 0 || nc > N) begin
      if (m_acq) begin
        m_run = 0;
        m_acq = 0;
        m_err = 1;
      end
    end else begin
      if (m_acq && (d == 0 || (m_last != 0 && d != m_last))) begin
        m_acq = 0;
        m_lock = 1;
      end else if (m_acq) m_last = d;
      m_code = nc;
    end
    m_dec = 0;
    m_wait = ST;
    q.delete();
  endtask
  always @(posedge clk) begin
    chk_en = 1;
    if (!rst_n) begin
      m_code = 0; m_last = 0; m_wait = 0; m_run = 0; m_acq = 0; m_lock = 0; m_err = 0; m_dec = 0;
      q.delete();
    end else if (stop) begin
      m_run = 0; m_acq = 0; m_lock = 0; m_err = 0; m_dec = 0; m_wait = 0;
      q.delete();
    end else if (start && !(m_run && m_acq)) begin
      m_code = 0; m_last = 0; m_run = 1; m_acq = 1; m_lock = 0; m_err = 0; m_dec = 0; m_wait = ST;
      q.delete();
    end else if (m_run) begin
      if (m_dec) decide();
      else if (m_wait > 0) m_wait--;
      else if (pd_valid) begin
        q.push_back(pd_late);
        if (q.size() == AW) m_dec = 1;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("m_code", int'(code), m_code);
    chk("m_select", int'(select), thermo(m_code));
    chk("m_busy", int'(busy), int'(m_run && m_acq));
    chk("m_locked", int'(locked), int'(m_lock));
    chk("m_err", int'(err), int'(m_err));
  end
  task automatic tick();
    @(negedge clk);
    alt++;
    pd_late = pd_mode == 0 ? m_code >= tgt : pd_mode == 1 ? pd_fix : pd_mode == 2 ? alt[0] : (m_code >= N ? alt[0] : 1'b0);
  endtask
  task automatic wait_lock();
    for (int i = 0; i < 300 && !locked; i++) tick();
    chk("lock_reached", int'(locked), 1);
  endtask
  initial begin
    rst_n = 0; start = 1; pd_valid = 1;
    tick();
    tick();
    chk("rst_select", int'(select), 4'b1111);
    chk("rst_code", int'(code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1; start = 0;
    repeat (3) tick();
    chk("idle_code", int'(code), 0);
    pd_mode = 0; tgt = 2;
    start = 1;
    tick();
    start = 0;
    repeat (12) tick();
    chk("acq_code_before", int'(code), 0);
    tick();
    chk("acq_code_first", int'(code), 1);
    chk("acq_select_1", int'(select), 4'b1110);
    chk("acq_busy", int'(busy), 1);
    wait_lock();
    chk("acq_lock_code", int'(code), 1);
    chk("acq_lock_busy", int'(busy), 0);
    pd_mode = 2;
    start = 1;
    tick();
    start = 0;
    chk("hold_restart_code", int'(code), 0);
    chk("hold_restart_busy", int'(busy), 1);
    wait_lock();
    chk("hold_code", int'(code), 0);
    repeat (30) tick();
    chk("hold_track_code", int'(code), 0);
    chk("hold_track_locked", int'(locked), 1);
    pd_mode = 1; pd_fix = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 300 && !err; i++) tick();
    chk("err_set", int'(err), 1);
    chk("err_code", int'(code), 4);
    chk("err_select", int'(select), 4'b0000);
    chk("err_locked", int'(locked), 0);
    chk("err_busy", int'(busy), 0);
    repeat (5) tick();
    chk("err_held", int'(err), 1);
    pd_mode = 3;
    start = 1;
    tick();
    start = 0;
    chk("err_clear", int'(err), 0);
    chk("err_restart_code", int'(code), 0);
    chk("err_restart_busy", int'(busy), 1);
    wait_lock();
    chk("sat_lock_code", int'(code), 4);
    pd_mode = 1; pd_fix = 0;
    repeat (40) tick();
    chk("sat_code", int'(code), 4);
    chk("sat_locked", int'(locked), 1);
    chk("sat_err", int'(err), 0);
    start = 1;
    tick();
    start = 0;
    repeat (33) tick();
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_code", int'(code), 2);
    chk("stop_locked", int'(locked), 0);
    pd_fix = 1;
    repeat (20) begin
      tick();
      pd_valid = ~pd_valid;
    end
    chk("stop_hold_code", int'(code), 2);
    chk("stop_hold_busy", int'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
